// File: rtl/alu_control_seq.sv
// Registered, valid/ready handshaked ALU control decoder with illegal-op
// detection and an iterative (multi-cycle) multiply mode. Optional counters: ALUCTL_STATS_EN.
module alu_control_seq #(
    parameter int unsigned FUNC_W    = 6,
    parameter int unsigned MC_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ALUop,
    input  logic [FUNC_W-1:0] func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        ALUctr,
    output logic              illegal,
    output logic              busy
`ifdef ALUCTL_STATS_EN
    ,
    output logic [15:0]       op_count,
    output logic [7:0]        illegal_count
`endif
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned OPC_W = 16;
    localparam int unsigned ILC_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_MULTI = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         ctr_q, ctr_d;
    logic               ill_q, ill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [2:0]         dec_ctr;
    logic               dec_ill;
    logic               dec_multi;
    logic               accept;

    // Opcode decode; R-type uses only func[2:0], upper func bits must be zero
    always_comb begin
        dec_ctr   = 3'b000;
        dec_ill   = 1'b0;
        dec_multi = 1'b0;
        case (ALUop)
            3'b000:  dec_ctr = 3'b000;
            3'b001:  dec_ctr = 3'b010;
            3'b010:  dec_ctr = 3'b000;
            3'b011:  dec_ctr = 3'b110;
            3'b100:  dec_ctr = 3'b111;
            3'b101:  dec_ctr = 3'b101;
            3'b110:  dec_ctr = 3'b100;
            default: begin
                if ((func >> 3) != '0) begin
                    dec_ill = 1'b1;
                end else begin
                    case (func[2:0])
                        3'b000:  dec_ctr = 3'b110;
                        3'b010:  dec_ctr = 3'b010;
                        3'b011:  dec_ctr = 3'b001;
                        3'b100:  dec_ctr = 3'b101;
                        3'b101:  dec_ctr = 3'b111;
                        3'b110: begin
                            dec_ctr   = 3'b011;
                            dec_multi = 1'b1;
                        end
                        default: dec_ill = 1'b1;
                    endcase
                end
            end
        endcase
    end

    // A held result frees the input slot in the same cycle it is consumed
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE:  in_ready = 1'b1;
            ST_HOLD:  in_ready = out_ready;
            default:  in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            ST_MULTI: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    ill_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
        // A new op overrides the drain/idle transition above
        if (accept) begin
            ctr_d = dec_ctr;
            ill_d = dec_ill;
            if (dec_multi) begin
                state_d = ST_MULTI;
                cnt_d   = CNT_W'(MC_CYCLES - 1);
            end else begin
                state_d = ST_HOLD;
            end
        end
    end

`ifdef ALUCTL_STATS_EN
    logic [OPC_W-1:0] op_cnt_q;
    logic [ILC_W-1:0] ill_cnt_q;
    logic             consumed;

    assign consumed = out_valid && out_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ctr_q     <= 3'b000;
            ill_q     <= 1'b0;
            cnt_q     <= '0;
`ifdef ALUCTL_STATS_EN
            op_cnt_q  <= '0;
            ill_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            ill_q     <= ill_d;
            cnt_q     <= cnt_d;
`ifdef ALUCTL_STATS_EN
            // Saturating usage counters
            if (consumed) begin
                if (op_cnt_q != '1) op_cnt_q <= op_cnt_q + OPC_W'(1);
                if (ill_q && (ill_cnt_q != '1)) ill_cnt_q <= ill_cnt_q + ILC_W'(1);
            end
`endif
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_MULTI);
    assign ALUctr    = ctr_q;
    assign illegal   = ill_q;

`ifdef ALUCTL_STATS_EN
    assign op_count      = op_cnt_q;
    assign illegal_count = ill_cnt_q;
`endif

endmodule
